// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN          : PC / instruction width
//   NOP_INST      : instruction presented to decode when nothing is buffered
//   fetch_state_e : fetch sequencer state encoding
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // free to issue a request
        WAIT  = 2'd1,   // one granted request outstanding, response wanted
        DRAIN = 2'd2    // one granted request outstanding, response to be discarded
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo_n_bit.sv
// Synchronous FIFO with a single-cycle flush.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the FIFO at the next edge; overrides push/pop
//   push/din : write din at the tail
//   pop/dout : dout is the head (combinational read); pop advances it
//   count    : number of valid entries (0..depth)
//   empty    : count == 0
//   full     : count == depth
module sync_fifo_n_bit #(
    parameter int width = 64,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic [$clog2(depth):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(depth);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage array has no reset; occupancy is tracked by count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues word-aligned fetches over req/gnt/rvalid,
// buffers {pc, inst} in a DEPTH-entry FIFO and presents the head to decode.
//   clk, rst                     : clock, synchronous active-high reset
//   imem_req/addr/gnt            : request channel (one outstanding request max)
//   imem_rvalid/rdata            : in-order response channel
//   redirect_valid/redirect_pc   : flush everything and restart at redirect_pc
//   dec_valid/ready              : head handshake towards decode
//   dec_inst/dec_pc/dec_pc4      : head instruction, its PC and PC+4
module fetch_prefetch_unit #(
    parameter int               DEPTH    = 4,
    parameter int               XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc4
);

    import rv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] redirect_pc_aligned;

    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [2*XLEN-1:0] fifo_din;
    logic [2*XLEN-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        push       = 1'b0;
        case (state_q)
            FETCH: begin
                // Issue only with room for the response: a push can then never hit a full FIFO.
                issue = (fifo_count < DEPTH_CNT) && !redirect_valid && !rst;
                if (issue && imem_gnt) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // A coincident redirect squashes this response but the bus is free again.
                    state_d = FETCH;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // A redirect always owns the next fetch address (last one wins, also in DRAIN).
        if (redirect_valid) fetch_pc_d = redirect_pc_aligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // fetch_pc was already advanced at grant time, so the response belongs to fetch_pc - 4.
    assign fifo_din   = {fetch_pc_q - PC_STEP, imem_rdata};
    assign head_valid = !fifo_empty && !rst;
    assign pop        = head_valid && dec_ready && !redirect_valid;

    sync_fifo_n_bit #(
        .width (2 * XLEN),
        .depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    assign dec_valid = head_valid;
    assign dec_inst  = head_valid ? fifo_dout[XLEN-1:0] : XLEN'(NOP_INST);
    assign dec_pc    = head_valid ? fifo_dout[2*XLEN-1:XLEN] : '0;
    assign dec_pc4   = dec_pc + PC_STEP;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: a one-slot memory responder,
// an address model, and a {pc, inst} scoreboard compared on every pop.
module tb_fetch_prefetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic            clk;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pc4;

    int total = 0;
    int bad   = 0;

    // responder controls and state
    int          rsp_delay  = 1;
    bit          rand_delay = 0;
    bit          pending    = 0;
    bit          p_stale    = 0;
    bit          cur_stale  = 0;
    int          cnt        = 0;
    logic [31:0] p_addr, p_exp, r_exp;
    logic [31:0] exp_addr   = RESET_PC;
    int          grant_cnt  = 0;
    int          pop_cnt    = 0;
    logic [63:0] sb [$];

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_pc4        (dec_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder + address model + scoreboard. Observes at negedge,
    // drives rvalid/rdata just after posedge.
    initial begin : responder
        logic        g_now;
        logic [31:0] g_addr;
        logic [63:0] e;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            g_now  = imem_req && imem_gnt && !rst;
            g_addr = imem_addr;
            if (rst) begin
                sb.delete();
                exp_addr = RESET_PC;
                if (pending) p_stale = 1'b1;
            end else if (redirect_valid) begin
                sb.delete();
                exp_addr = redirect_pc & 32'hFFFFFFFC;
                if (pending) p_stale = 1'b1;
            end else begin
                if (dec_valid && dec_ready) begin
                    pop_cnt++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_pop: got pc=%h with nothing expected", dec_pc);
                    end else begin
                        e = sb.pop_front();
                        if (dec_pc !== e[63:32]) begin
                            bad++;
                            $display("FAIL sb_pc: got %h want %h", dec_pc, e[63:32]);
                        end
                        total++;
                        if (dec_inst !== e[31:0]) begin
                            bad++;
                            $display("FAIL sb_inst: got %h want %h", dec_inst, e[31:0]);
                        end
                        total++;
                        if (dec_pc4 !== e[63:32] + 32'd4) begin
                            bad++;
                            $display("FAIL sb_pc4: got %h want %h", dec_pc4, e[63:32] + 32'd4);
                        end
                    end
                end
                if (imem_rvalid && !cur_stale) sb.push_back({r_exp, inst_of(r_exp)});
            end
            if (g_now) begin
                total++;
                if (g_addr !== exp_addr) begin
                    bad++;
                    $display("FAIL grant_addr: got %h want %h", g_addr, exp_addr);
                end
                grant_cnt++;
                p_exp    = exp_addr;
                exp_addr = exp_addr + 32'd4;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (g_now) begin
                pending = 1'b1;
                p_stale = 1'b0;
                p_addr  = g_addr;
                cnt     = rand_delay ? int'($urandom_range(1, 3)) : rsp_delay;
            end
            if (pending) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst_of(p_addr);
                    cur_stale   = p_stale;
                    r_exp       = p_exp;
                    pending     = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b0)  begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", dec_valid); end
        total++; if (dec_inst !== NOP)   begin bad++; $display("FAIL rst_inst: got %h want %h", dec_inst, NOP); end
        total++; if (dec_pc !== 32'h0)   begin bad++; $display("FAIL rst_pc: got %h want 0", dec_pc); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1)      begin bad++; $display("FAIL first_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL first_addr: got %h want %h", imem_addr, RESET_PC); end
        tick();
        @(negedge clk);
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rv_latency_early: got %b want 0", dec_valid); end
        tick();
        @(negedge clk);
        total++; if (dec_valid !== 1'b1)          begin bad++; $display("FAIL rv_latency: got %b want 1", dec_valid); end
        total++; if (dec_pc !== RESET_PC)         begin bad++; $display("FAIL first_pc: got %h want %h", dec_pc, RESET_PC); end
        total++; if (dec_inst !== inst_of(RESET_PC)) begin bad++; $display("FAIL first_inst: got %h want %h", dec_inst, inst_of(RESET_PC)); end
    endtask

    task automatic test_stream();
        int p0;
        bit done;
        tick();
        dec_ready = 1'b1;
        p0 = pop_cnt;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (pop_cnt >= p0 + 8) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL stream_progress: got %0d pops want 8", pop_cnt - p0); end
    endtask

    task automatic test_backpressure();
        int g0, p0;
        bit done;
        rst = 1'b1; dec_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        g0 = grant_cnt;
        repeat (9) tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b0)   begin bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
        total++; if (dec_valid !== 1'b1)  begin bad++; $display("FAIL bp_valid: got %b want 1", dec_valid); end
        total++; if (dec_pc !== 32'h0)    begin bad++; $display("FAIL bp_head: got %h want 0", dec_pc); end
        total++; if (grant_cnt - g0 !== 4) begin bad++; $display("FAIL bp_fill: got %0d grants want 4", grant_cnt - g0); end
        tick();
        dec_ready = 1'b1;
        p0 = pop_cnt;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (pop_cnt >= p0 + 6) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL bp_drain: got %0d pops want 6", pop_cnt - p0); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        @(negedge clk);
        rsp_delay = 3;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL rw_grant: no grant seen"); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h00000100;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_drain_req: got %b want 0", imem_req); end
        tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_rvalid_req: got %b want 0", imem_req); end
        tick();
        @(negedge clk);
        rsp_delay = 1;
        total++; if (imem_req !== 1'b1)           begin bad++; $display("FAIL rw_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h00000100)  begin bad++; $display("FAIL rw_addr: got %h want 100", imem_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            @(negedge clk);
            if (dec_valid) found = 1'b1;
        end
        total++; if (dec_pc !== 32'h00000100) begin bad++; $display("FAIL rw_first_pc: got %h want 100", dec_pc); end
    endtask

    task automatic test_redirect_coincident();
        bit found;
        tick();
        dec_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && dec_valid) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL rc_setup: no grant with buffered entry"); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h00000203; dec_ready = 1'b1;
        @(negedge clk);
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL rc_preflush_valid: got %b want 1", dec_valid); end
        tick();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        total++; if (dec_valid !== 1'b0)          begin bad++; $display("FAIL rc_flush: got %b want 0", dec_valid); end
        total++; if (imem_req !== 1'b1)           begin bad++; $display("FAIL rc_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h00000200)  begin bad++; $display("FAIL rc_addr: got %h want 200", imem_addr); end
    endtask

    task automatic test_gnt_stall();
        bit found;
        tick();
        imem_gnt = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h00000040;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b1)          begin bad++; $display("FAIL gs_req[%0d]: got %b want 1", i, imem_req); end
            total++; if (imem_addr !== 32'h00000040) begin bad++; $display("FAIL gs_addr[%0d]: got %h want 40", i, imem_addr); end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h00000300;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL gs_redir_req: got %b want 0", imem_req); end
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b1; dec_ready = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1)          begin bad++; $display("FAIL gs_restart_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h00000300) begin bad++; $display("FAIL gs_restart_addr: got %h want 300", imem_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            @(negedge clk);
            if (dec_valid) found = 1'b1;
        end
        total++; if (dec_pc !== 32'h00000300) begin bad++; $display("FAIL gs_first_pc: got %h want 300", dec_pc); end
    endtask

    task automatic test_wrap();
        bit found, seen, done;
        int p0;
        @(negedge clk);
        rand_delay = 1'b1;
        tick();
        dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dec_valid) found = 1'b1;
            else tick();
        end
        total++; if (dec_pc !== 32'hFFFFFFF8)  begin bad++; $display("FAIL wrap_first_pc: got %h want fffffff8", dec_pc); end
        total++; if (dec_pc4 !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_first_pc4: got %h want fffffffc", dec_pc4); end
        p0 = pop_cnt;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            dec_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (dec_valid && dec_pc === 32'hFFFFFFFC && !seen) begin
                seen = 1'b1;
                total++; if (dec_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 0", dec_pc4); end
            end
            if (pop_cnt >= p0 + 20) done = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL wrap_seen: pc fffffffc never presented"); end
        total++; if (!done) begin bad++; $display("FAIL wrap_progress: got %0d pops want 20", pop_cnt - p0); end
    endtask

    task automatic test_final_drain();
        @(negedge clk);
        rand_delay = 1'b0;
        rsp_delay  = 1;
        tick();
        imem_gnt  = 1'b0;
        dec_ready = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", dec_valid); end
        total++; if (sb.size() != 0)     begin bad++; $display("FAIL drain_sb: got %0d left want 0", sb.size()); end
    endtask

    initial begin : main
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_gnt_stall();
        test_wrap();
        test_final_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
